// File: rtl/axi4_arb_pkg.sv
// Shared types for the AXI4 master arbiter.
// FSM state encodings and grant-width helper.
package axi4_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  function automatic int arb_gnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_MASTERS_DEF = 2;
  localparam int GNT_WIDTH = arb_gnt_width(N_MASTERS_DEF);

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle (no cache/prot/lock sideband).
// master drives requests, slave drives responses.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 128,
  parameter int AXI4_ID_WIDTH      = 4
);
  localparam int SW = AXI4_DATA_WIDTH / 8;

  logic [AXI4_ID_WIDTH-1:0]      AWID;
  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR;
  logic [7:0]                    AWLEN;
  logic [2:0]                    AWSIZE;
  logic [1:0]                    AWBURST;
  logic                          AWVALID;
  logic                          AWREADY;

  logic [AXI4_DATA_WIDTH-1:0]    WDATA;
  logic [SW-1:0]                 WSTRB;
  logic                          WLAST;
  logic                          WVALID;
  logic                          WREADY;

  logic [AXI4_ID_WIDTH-1:0]      BID;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;

  logic [AXI4_ID_WIDTH-1:0]      ARID;
  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR;
  logic [7:0]                    ARLEN;
  logic [2:0]                    ARSIZE;
  logic [1:0]                    ARBURST;
  logic                          ARVALID;
  logic                          ARREADY;

  logic [AXI4_ID_WIDTH-1:0]      RID;
  logic [AXI4_DATA_WIDTH-1:0]    RDATA;
  logic [1:0]                    RRESP;
  logic                          RLAST;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_rr_arbiter.sv
// Combinational round-robin pick: first requester
// at or after ptr, wrapping in index order.
module axi4_rr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int GW = arb_gnt_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [GW-1:0] w_sel;

  // Descending scan so the closest requester wins last
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_sel     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sel = GW'((int'(ptr) + k) % N);
      if (req[w_sel]) begin
        gnt_idx   = w_sel;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_master_arbiter.sv
// N-to-1 AXI4 master arbiter, independent
// round-robin write and read paths.
module axi4_master_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 128,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int N_MASTERS          = 2
) (
  input logic   clk,
  input logic   rstn,
  axi4_if.slave m [N_MASTERS],
  axi4_if.master s
);

  localparam int GW = arb_gnt_width(N_MASTERS);
  localparam int AW = AXI4_ADDRESS_WIDTH;
  localparam int DW = AXI4_DATA_WIDTH;
  localparam int IW = AXI4_ID_WIDTH;
  localparam int SW = DW / 8;
  localparam int NM = N_MASTERS;

  logic [NM-1:0] w_awvalid, w_wvalid, w_wlast;
  logic [NM-1:0] w_bready, w_arvalid, w_rready;
  logic [IW-1:0] w_awid [NM];
  logic [AW-1:0] w_awaddr [NM];
  logic [7:0]    w_awlen [NM];
  logic [2:0]    w_awsize [NM];
  logic [1:0]    w_awburst [NM];
  logic [DW-1:0] w_wdata [NM];
  logic [SW-1:0] w_wstrb [NM];
  logic [IW-1:0] w_arid [NM];
  logic [AW-1:0] w_araddr [NM];
  logic [7:0]    w_arlen [NM];
  logic [2:0]    w_arsize [NM];
  logic [1:0]    w_arburst [NM];

  wr_state_e     r_wr_st, w_wr_nxt;
  rd_state_e     r_rd_st, w_rd_nxt;
  logic [GW-1:0] r_wr_gnt, r_wr_ptr, w_wr_idx;
  logic [GW-1:0] r_rd_gnt, r_rd_ptr, w_rd_idx;
  logic          w_wr_gv, w_rd_gv;
  logic          w_aw_on, w_w_on, w_b_on;
  logic          w_ar_on, w_r_on;
  logic          w_aw_hs, w_wl_hs, w_b_hs;
  logic          w_ar_hs, w_rl_hs;

  function automatic logic [GW-1:0] f_inc(
    input logic [GW-1:0] g
  );
    return (32'(g) == 32'(NM - 1)) ? '0 : g + 1'b1;
  endfunction

  axi4_rr_arbiter #(.N(NM)) u_wr_arb (
    .req       (w_awvalid),
    .ptr       (r_wr_ptr),
    .gnt_idx   (w_wr_idx),
    .gnt_valid (w_wr_gv)
  );

  axi4_rr_arbiter #(.N(NM)) u_rd_arb (
    .req       (w_arvalid),
    .ptr       (r_rd_ptr),
    .gnt_idx   (w_rd_idx),
    .gnt_valid (w_rd_gv)
  );

  assign w_aw_on = (r_wr_st == W_ADDR);
  assign w_w_on  = (r_wr_st == W_DATA);
  assign w_b_on  = (r_wr_st == W_RESP);
  assign w_ar_on = (r_rd_st == R_ADDR);
  assign w_r_on  = (r_rd_st == R_DATA);

  assign w_aw_hs = s.AWVALID & s.AWREADY;
  assign w_wl_hs = s.WVALID & s.WREADY & s.WLAST;
  assign w_b_hs  = s.BVALID & s.BREADY;
  assign w_ar_hs = s.ARVALID & s.ARREADY;
  assign w_rl_hs = s.RVALID & s.RREADY & s.RLAST;

  always_comb begin
    w_wr_nxt = r_wr_st;
    unique case (r_wr_st)
      W_IDLE: if (w_wr_gv) w_wr_nxt = W_ADDR;
      W_ADDR: if (w_aw_hs) w_wr_nxt = W_DATA;
      W_DATA: if (w_wl_hs) w_wr_nxt = W_RESP;
      W_RESP: if (w_b_hs)  w_wr_nxt = W_IDLE;
      default: w_wr_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_nxt = r_rd_st;
    unique case (r_rd_st)
      R_IDLE: if (w_rd_gv) w_rd_nxt = R_ADDR;
      R_ADDR: if (w_ar_hs) w_rd_nxt = R_DATA;
      R_DATA: if (w_rl_hs) w_rd_nxt = R_IDLE;
      default: w_rd_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_st  <= W_IDLE;
      r_wr_gnt <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_wr_st <= w_wr_nxt;
      if (r_wr_st == W_IDLE && w_wr_gv)
        r_wr_gnt <= w_wr_idx;
      if (w_b_on && w_b_hs)
        r_wr_ptr <= f_inc(r_wr_gnt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_st  <= R_IDLE;
      r_rd_gnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_rd_st <= w_rd_nxt;
      if (r_rd_st == R_IDLE && w_rd_gv)
        r_rd_gnt <= w_rd_idx;
      if (w_r_on && w_rl_hs)
        r_rd_ptr <= f_inc(r_rd_gnt);
    end
  end

  // Downstream request muxes; zero whenever not forwarding
  assign s.AWVALID = w_aw_on & w_awvalid[r_wr_gnt];
  assign s.AWID    = w_aw_on ? w_awid[r_wr_gnt]    : '0;
  assign s.AWADDR  = w_aw_on ? w_awaddr[r_wr_gnt]  : '0;
  assign s.AWLEN   = w_aw_on ? w_awlen[r_wr_gnt]   : '0;
  assign s.AWSIZE  = w_aw_on ? w_awsize[r_wr_gnt]  : '0;
  assign s.AWBURST = w_aw_on ? w_awburst[r_wr_gnt] : '0;
  assign s.WVALID  = w_w_on & w_wvalid[r_wr_gnt];
  assign s.WLAST   = w_w_on & w_wlast[r_wr_gnt];
  assign s.WDATA   = w_w_on ? w_wdata[r_wr_gnt] : '0;
  assign s.WSTRB   = w_w_on ? w_wstrb[r_wr_gnt] : '0;
  assign s.BREADY  = w_b_on & w_bready[r_wr_gnt];
  assign s.ARVALID = w_ar_on & w_arvalid[r_rd_gnt];
  assign s.ARID    = w_ar_on ? w_arid[r_rd_gnt]    : '0;
  assign s.ARADDR  = w_ar_on ? w_araddr[r_rd_gnt]  : '0;
  assign s.ARLEN   = w_ar_on ? w_arlen[r_rd_gnt]   : '0;
  assign s.ARSIZE  = w_ar_on ? w_arsize[r_rd_gnt]  : '0;
  assign s.ARBURST = w_ar_on ? w_arburst[r_rd_gnt] : '0;
  assign s.RREADY  = w_r_on & w_rready[r_rd_gnt];

  for (genvar i = 0; i < NM; i++) begin : g_m
    logic w_ws, w_rs, w_bs, w_rds;
    assign w_ws  = (r_wr_gnt == GW'(i));
    assign w_rs  = (r_rd_gnt == GW'(i));
    assign w_bs  = w_b_on & w_ws;
    assign w_rds = w_r_on & w_rs;

    assign w_awvalid[i] = m[i].AWVALID;
    assign w_awid[i]    = m[i].AWID;
    assign w_awaddr[i]  = m[i].AWADDR;
    assign w_awlen[i]   = m[i].AWLEN;
    assign w_awsize[i]  = m[i].AWSIZE;
    assign w_awburst[i] = m[i].AWBURST;
    assign w_wvalid[i]  = m[i].WVALID;
    assign w_wlast[i]   = m[i].WLAST;
    assign w_wdata[i]   = m[i].WDATA;
    assign w_wstrb[i]   = m[i].WSTRB;
    assign w_bready[i]  = m[i].BREADY;
    assign w_arvalid[i] = m[i].ARVALID;
    assign w_arid[i]    = m[i].ARID;
    assign w_araddr[i]  = m[i].ARADDR;
    assign w_arlen[i]   = m[i].ARLEN;
    assign w_arsize[i]  = m[i].ARSIZE;
    assign w_arburst[i] = m[i].ARBURST;
    assign w_rready[i]  = m[i].RREADY;

    assign m[i].AWREADY = w_aw_on & w_ws & s.AWREADY;
    assign m[i].WREADY  = w_w_on & w_ws & s.WREADY;
    assign m[i].BVALID  = w_bs & s.BVALID;
    assign m[i].BID     = w_bs ? s.BID : '0;
    assign m[i].BRESP   = w_bs ? s.BRESP : '0;
    assign m[i].ARREADY = w_ar_on & w_rs & s.ARREADY;
    assign m[i].RVALID  = w_rds & s.RVALID;
    assign m[i].RLAST   = w_rds & s.RLAST;
    assign m[i].RID     = w_rds ? s.RID : '0;
    assign m[i].RDATA   = w_rds ? s.RDATA : '0;
    assign m[i].RRESP   = w_rds ? s.RRESP : '0;
  end

endmodule

// File: tb/tb_axi4_master_arbiter.sv
// Directed bench for axi4_master_arbiter, two masters.
// Master and slave sides are driven by hand.
module tb_axi4_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int IW = 4;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  axi4_if #(
    .AXI4_ADDRESS_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW)
  ) m_if [N] ();

  axi4_if #(
    .AXI4_ADDRESS_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW)
  ) s_if ();

  logic          t_awvalid [N];
  logic [AW-1:0] t_awaddr [N];
  logic [7:0]    t_awlen [N];
  logic          t_wvalid [N];
  logic [DW-1:0] t_wdata [N];
  logic          t_wlast [N];
  logic          t_bready [N];
  logic          t_arvalid [N];
  logic [AW-1:0] t_araddr [N];
  logic [7:0]    t_arlen [N];
  logic          t_rready [N];

  logic          o_awready [N];
  logic          o_wready [N];
  logic          o_bvalid [N];
  logic [IW-1:0] o_bid [N];
  logic [1:0]    o_bresp [N];
  logic          o_arready [N];
  logic          o_rvalid [N];
  logic          o_rlast [N];
  logic [IW-1:0] o_rid [N];
  logic [DW-1:0] o_rdata [N];
  logic [1:0]    o_rresp [N];

  for (genvar g = 0; g < N; g++) begin : g_m
    assign m_if[g].AWVALID = t_awvalid[g];
    assign m_if[g].AWID    = IW'(g + 1);
    assign m_if[g].AWADDR  = t_awaddr[g];
    assign m_if[g].AWLEN   = t_awlen[g];
    assign m_if[g].AWSIZE  = 3'd4;
    assign m_if[g].AWBURST = 2'b01;
    assign m_if[g].WVALID  = t_wvalid[g];
    assign m_if[g].WDATA   = t_wdata[g];
    assign m_if[g].WSTRB   = '1;
    assign m_if[g].WLAST   = t_wlast[g];
    assign m_if[g].BREADY  = t_bready[g];
    assign m_if[g].ARVALID = t_arvalid[g];
    assign m_if[g].ARID    = IW'(g + 1);
    assign m_if[g].ARADDR  = t_araddr[g];
    assign m_if[g].ARLEN   = t_arlen[g];
    assign m_if[g].ARSIZE  = 3'd4;
    assign m_if[g].ARBURST = 2'b01;
    assign m_if[g].RREADY  = t_rready[g];
    assign o_awready[g] = m_if[g].AWREADY;
    assign o_wready[g]  = m_if[g].WREADY;
    assign o_bvalid[g]  = m_if[g].BVALID;
    assign o_bid[g]     = m_if[g].BID;
    assign o_bresp[g]   = m_if[g].BRESP;
    assign o_arready[g] = m_if[g].ARREADY;
    assign o_rvalid[g]  = m_if[g].RVALID;
    assign o_rlast[g]   = m_if[g].RLAST;
    assign o_rid[g]     = m_if[g].RID;
    assign o_rdata[g]   = m_if[g].RDATA;
    assign o_rresp[g]   = m_if[g].RRESP;
  end

  axi4_master_arbiter #(
    .AXI4_ADDRESS_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW),
    .N_MASTERS(N)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .m    (m_if),
    .s    (s_if)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A granted master holding AWVALID must see it stay high
  logic r_aw_pend = 1'b0;
  always @(negedge clk) begin
    if (rstn && r_aw_pend && !s_if.AWVALID)
      check("aw_withdraw", s_if.AWVALID, 1);
    r_aw_pend <= rstn & s_if.AWVALID & ~s_if.AWREADY;
  end

  task automatic wr_txn(
    input int         g,
    input int         beats,
    input bit         bp,
    input logic [1:0] bresp,
    input logic [3:0] id
  );
    int o;
    int b;
    int cyc;
    logic [31:0] w;
    o = 1 - g;
    s_if.AWREADY = 1'b1;
    #1;
    check("aw_bubble", s_if.AWVALID, 0);
    tick();
    check("aw_valid", s_if.AWVALID, 1);
    check("aw_addr", s_if.AWADDR, t_awaddr[g]);
    check("aw_len", s_if.AWLEN, t_awlen[g]);
    check("aw_id", s_if.AWID, g + 1);
    check("aw_rdy_gnt", o_awready[g], 1);
    check("aw_rdy_oth", o_awready[o], 0);
    tick();
    t_awvalid[g] = 1'b0;
    s_if.AWREADY = 1'b0;
    b = 0;
    cyc = 0;
    while (b < beats && cyc < 200) begin
      w = 32'h1000 * (g + 1) + 32'(b);
      t_wvalid[g] = 1'b1;
      t_wdata[g] = DW'(w);
      t_wlast[g] = (b == beats - 1);
      s_if.WREADY = bp ? ~cyc[0] : 1'b1;
      #1;
      check("w_data", s_if.WDATA, DW'(w));
      check("w_last", s_if.WLAST, b == beats - 1);
      check("w_rdy_gnt", o_wready[g], s_if.WREADY);
      check("w_rdy_oth", o_wready[o], 0);
      check("aw_rdy_oth_w", o_awready[o], 0);
      if (s_if.WREADY) b++;
      cyc++;
      tick();
    end
    if (cyc >= 200) check("w_timeout", 0, 1);
    t_wvalid[g] = 1'b0;
    t_wlast[g] = 1'b0;
    s_if.WREADY = 1'b0;
    s_if.BVALID = 1'b1;
    s_if.BRESP = bresp;
    s_if.BID = id;
    t_bready[g] = 1'b1;
    #1;
    check("b_valid_gnt", o_bvalid[g], 1);
    check("b_resp_gnt", o_bresp[g], bresp);
    check("b_id_gnt", o_bid[g], id);
    check("b_valid_oth", o_bvalid[o], 0);
    check("b_resp_oth", o_bresp[o], 0);
    check("s_bready", s_if.BREADY, 1);
    tick();
    s_if.BVALID = 1'b0;
    s_if.BRESP = '0;
    t_bready[g] = 1'b0;
    #1;
    check("wr_ptr", dut.r_wr_ptr, (g + 1) % N);
  endtask

  task automatic rd_txn(
    input int         g,
    input int         beats,
    input logic [1:0] rresp,
    input logic [3:0] id
  );
    int o;
    o = 1 - g;
    s_if.ARREADY = 1'b1;
    #1;
    check("ar_bubble", s_if.ARVALID, 0);
    tick();
    check("ar_valid", s_if.ARVALID, 1);
    check("ar_addr", s_if.ARADDR, t_araddr[g]);
    check("ar_len", s_if.ARLEN, t_arlen[g]);
    check("ar_rdy_gnt", o_arready[g], 1);
    check("ar_rdy_oth", o_arready[o], 0);
    tick();
    t_arvalid[g] = 1'b0;
    s_if.ARREADY = 1'b0;
    for (int b = 0; b < beats; b++) begin
      s_if.RVALID = 1'b1;
      s_if.RDATA = DW'(32'hB000 + 32'(b));
      s_if.RLAST = (b == beats - 1);
      s_if.RID = id;
      s_if.RRESP = rresp;
      t_rready[g] = 1'b1;
      #1;
      check("r_valid_gnt", o_rvalid[g], 1);
      check("r_data_gnt", o_rdata[g], 32'hB000 + b);
      check("r_last_gnt", o_rlast[g], b == beats - 1);
      check("r_id_gnt", o_rid[g], id);
      check("r_resp_gnt", o_rresp[g], rresp);
      check("r_valid_oth", o_rvalid[o], 0);
      check("r_resp_oth", o_rresp[o], 0);
      check("s_rready", s_if.RREADY, 1);
      tick();
    end
    s_if.RVALID = 1'b0;
    s_if.RLAST = 1'b0;
    s_if.RRESP = '0;
    t_rready[g] = 1'b0;
    #1;
    check("rd_ptr", dut.r_rd_ptr, (g + 1) % N);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      t_awvalid[i] = 1'b0; t_awaddr[i] = '0;
      t_awlen[i] = '0;     t_wvalid[i] = 1'b0;
      t_wdata[i] = '0;     t_wlast[i] = 1'b0;
      t_bready[i] = 1'b0;  t_arvalid[i] = 1'b0;
      t_araddr[i] = '0;    t_arlen[i] = '0;
      t_rready[i] = 1'b0;
    end
    s_if.AWREADY = 1'b0; s_if.WREADY = 1'b0;
    s_if.BVALID = 1'b0;  s_if.BRESP = '0;
    s_if.BID = '0;       s_if.ARREADY = 1'b0;
    s_if.RVALID = 1'b0;  s_if.RDATA = '0;
    s_if.RLAST = 1'b0;   s_if.RID = '0;
    s_if.RRESP = '0;

    // reset state
    repeat (2) tick();
    check("rst_awvalid", s_if.AWVALID, 0);
    check("rst_arvalid", s_if.ARVALID, 0);
    check("rst_wvalid", s_if.WVALID, 0);
    check("rst_awready0", o_awready[0], 0);
    check("rst_wr_ptr", dut.r_wr_ptr, 0);
    rstn = 1'b1;
    #1;
    check("post_rst_bready", s_if.BREADY, 0);
    check("post_rst_rready", s_if.RREADY, 0);

    // single write from m0
    t_awvalid[0] = 1'b1;
    t_awaddr[0] = 32'h1000;
    t_awlen[0] = 8'd3;
    wr_txn(0, 4, 1'b0, 2'd0, 4'h5);

    // two contending masters, four writes each
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    t_awaddr[0] = 32'h3000;
    t_awaddr[1] = 32'h4000;
    t_awlen[0] = 8'd0;
    t_awlen[1] = 8'd0;
    for (int k = 0; k < 8; k++) begin
      t_awvalid[0] = 1'b1;
      t_awvalid[1] = 1'b1;
      wr_txn(k % 2, 1, 1'b0, 2'd0, 4'(k));
    end
    t_awvalid[0] = 1'b0;
    t_awvalid[1] = 1'b0;
    #1;

    // m1 reads while m0 writes
    t_awvalid[0] = 1'b1;
    t_awaddr[0] = 32'h1100;
    t_awlen[0] = 8'd3;
    t_arvalid[1] = 1'b1;
    t_araddr[1] = 32'h2000;
    t_arlen[1] = 8'd7;
    fork
      wr_txn(0, 4, 1'b0, 2'd0, 4'h2);
      rd_txn(1, 8, 2'd0, 4'h3);
      begin
        @(posedge clk);
        #3;
        check("overlap", {s_if.AWVALID, s_if.ARVALID}, 2'b11);
      end
    join

    // backpressured 16-beat burst
    t_awvalid[1] = 1'b1;
    t_awaddr[1] = 32'h5000;
    t_awlen[1] = 8'd15;
    wr_txn(1, 16, 1'b1, 2'd0, 4'h4);

    // reset in the middle of a write burst
    t_awvalid[0] = 1'b1;
    t_awaddr[0] = 32'h6000;
    t_awlen[0] = 8'd3;
    s_if.AWREADY = 1'b1;
    tick();
    tick();
    t_awvalid[0] = 1'b0;
    s_if.AWREADY = 1'b0;
    s_if.WREADY = 1'b1;
    for (int b = 0; b < 2; b++) begin
      t_wvalid[0] = 1'b1;
      t_wdata[0] = DW'(32'h60 + 32'(b));
      tick();
    end
    t_wvalid[0] = 1'b1;
    t_wdata[0] = DW'(32'h62);
    #1;
    check("pre_rst_wvalid", s_if.WVALID, 1);
    rstn = 1'b0;
    #1;
    check("arst_wvalid", s_if.WVALID, 0);
    check("arst_wready0", o_wready[0], 0);
    check("arst_wdata", s_if.WDATA, 0);
    check("arst_bready", s_if.BREADY, 0);
    check("arst_wr_ptr", dut.r_wr_ptr, 0);
    t_wvalid[0] = 1'b0;
    s_if.WREADY = 1'b0;
    tick();
    rstn = 1'b1;
    t_awvalid[1] = 1'b1;
    t_awaddr[1] = 32'h7000;
    t_awlen[1] = 8'd3;
    wr_txn(1, 4, 1'b0, 2'd0, 4'h7);

    // error responses
    t_awvalid[0] = 1'b1;
    t_awaddr[0] = 32'h8000;
    t_awlen[0] = 8'd0;
    t_arvalid[1] = 1'b1;
    t_araddr[1] = 32'h9000;
    t_arlen[1] = 8'd0;
    fork
      wr_txn(0, 1, 1'b0, 2'd2, 4'h9);
      rd_txn(1, 1, 2'd3, 4'h6);
    join

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
